sram_bank: RTL and testbench



---
 rtl/sram_pkg.sv | 51 +++++
 rtl/sram_bank_if.sv | 38 +++
 rtl/sram_bank_seq.sv | 83 ++++++++
 rtl/sram_bank.sv | 129 ++++++++++++
 tb/tb_sram_bank.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM bank controller:
//   - state_t      : sequencer phase encoding
//   - DEF_*        : default geometry and derived sizes for the standard bank
//   - cnt_width()  : width of the phase down-counter
//   - rows_of()/cols_of()/addr_w_of() : derive geometry from the parameters
// No ports (package).
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ACT   = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int unsigned DEF_ROW_BITS      = 6;
  localparam int unsigned DEF_COL_BITS      = 4;
  localparam int unsigned DEF_WORD_SIZE     = 4;
  localparam int unsigned DEF_ROWS          = 1 << DEF_ROW_BITS;
  localparam int unsigned DEF_WORDS_PER_ROW = 1 << DEF_COL_BITS;
  localparam int unsigned DEF_COLS          = DEF_WORD_SIZE * DEF_WORDS_PER_ROW;
  localparam int unsigned DEF_ADDR_W        = DEF_ROW_BITS + DEF_COL_BITS;

  // Counter must hold the longer of the two phase lengths.
  function automatic int unsigned cnt_width(input int unsigned pre_cycles,
                                            input int unsigned acc_cycles);
    int unsigned longest;
    longest = (pre_cycles > acc_cycles) ? pre_cycles : acc_cycles;
    return $clog2(longest + 1);
  endfunction

  function automatic int unsigned rows_of(input int unsigned row_bits);
    return 1 << row_bits;
  endfunction

  function automatic int unsigned cols_of(input int unsigned col_bits,
                                          input int unsigned word_size);
    return word_size * (1 << col_bits);
  endfunction

  function automatic int unsigned addr_w_of(input int unsigned row_bits,
                                            input int unsigned col_bits);
    return row_bits + col_bits;
  endfunction

endpackage

// File: rtl/sram_bank_if.sv
// -----------------------------------------------------------------------------
// sram_bank_if
// Digital-side request/response bundle of the SRAM bank controller.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_rnw             : 1 = read, 0 = write
//   req_addr            : {row, col}, row in the upper bits
//   req_wdata/req_wmask : write data and per-bit write enable
//   rsp_valid           : one-cycle completion strobe
//   rsp_is_read         : completed operation was a read
//   rsp_rdata           : last read data, held between reads
// Modports: master (requester), slave (controller).
// -----------------------------------------------------------------------------
interface sram_bank_if #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WORD_SIZE = 4
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rnw;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic [WORD_SIZE-1:0] req_wmask;
  logic                 rsp_valid;
  logic                 rsp_is_read;
  logic [WORD_SIZE-1:0] rsp_rdata;

  modport master (
    output req_valid, req_rnw, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_is_read, rsp_rdata
  );

  modport slave (
    input  req_valid, req_rnw, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_is_read, rsp_rdata
  );

endinterface

// File: rtl/sram_bank_seq.sv
// -----------------------------------------------------------------------------
// sram_bank_seq
// Phase sequencer: state register, phase down-counter and next-state logic.
//   clk, rst_n : clock, async active-low reset
//   i_start    : request accepted this cycle (only meaningful in IDLE)
//   i_rnw      : captured operation type, selects READ or WRITE after ACT
//   o_state    : current phase
//   o_last     : current cycle is the last one of a counted phase
// -----------------------------------------------------------------------------
module sram_bank_seq
  import sram_pkg::*;
#(
  parameter int unsigned PRE_CYCLES = 1,
  parameter int unsigned ACC_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_start,
  input  logic   i_rnw,
  output state_t o_state,
  output logic   o_last
);

  localparam int unsigned         CNT_W    = cnt_width(PRE_CYCLES, ACC_CYCLES);
  localparam logic [CNT_W-1:0]    PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    ACC_LOAD = CNT_W'(ACC_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter is loaded with length-1 on entry to a counted phase and the
  // phase ends on the cycle it reads zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_PRE;
          w_cnt_next   = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (w_cnt_zero) w_state_next = ST_ACT;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      ST_ACT: begin
        w_state_next = i_rnw ? ST_READ : ST_WRITE;
        w_cnt_next   = ACC_LOAD;
      end
      ST_READ, ST_WRITE: begin
        if (w_cnt_zero) w_state_next = ST_DONE;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_state = r_state;
  assign o_last  = w_cnt_zero;

endmodule

// File: rtl/sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
// SRAM bank controller: sequences precharge, wordline, sense and write-drive
// phases for an analog array of 2^ROW_BITS rows x WORD_SIZE*2^COL_BITS columns.
//   clk, rst_n  : clock, async active-low reset
//   bus         : request/response port (sram_bank_if.slave)
//   pre_en      : precharge/equalise enable
//   wl          : one-hot wordline
//   sae         : sense-amp enable
//   bl_drv_en   : per-column write-driver enable
//   bl_data     : driven bitline value (complement generated analog-side)
//   sense_data  : sense-amp outputs
// All array controls are decoded from registered state and operands only.
// -----------------------------------------------------------------------------
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned ROW_BITS   = DEF_ROW_BITS,
  parameter int unsigned COL_BITS   = DEF_COL_BITS,
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned PRE_CYCLES = 1,
  parameter int unsigned ACC_CYCLES = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  sram_bank_if.slave                             bus,
  output logic                                   pre_en,
  output logic [(1 << ROW_BITS)-1:0]             wl,
  output logic                                   sae,
  output logic [WORD_SIZE*(1 << COL_BITS)-1:0]   bl_drv_en,
  output logic [WORD_SIZE*(1 << COL_BITS)-1:0]   bl_data,
  input  logic [WORD_SIZE*(1 << COL_BITS)-1:0]   sense_data
);

  localparam int unsigned ROWS   = rows_of(ROW_BITS);
  localparam int unsigned COLS   = cols_of(COL_BITS, WORD_SIZE);
  localparam int unsigned ADDR_W = addr_w_of(ROW_BITS, COL_BITS);

  state_t               w_state;
  logic                 w_last;
  logic                 w_idle;
  logic                 w_accept;
  logic                 w_wl_on;
  logic                 w_capture;
  logic [ROWS-1:0]      w_row_onehot;
  logic [COLS-1:0]      w_mask_steer;
  logic [COLS-1:0]      w_data_steer;
  logic [WORD_SIZE-1:0] w_sense_word;

  logic                 r_rnw;
  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_wmask;
  logic [WORD_SIZE-1:0] r_rdata;

  assign w_idle   = (w_state == ST_IDLE);
  assign w_accept = w_idle && bus.req_valid;

  sram_bank_seq #(
    .PRE_CYCLES (PRE_CYCLES),
    .ACC_CYCLES (ACC_CYCLES)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_rnw   (r_rnw),
    .o_state (w_state),
    .o_last  (w_last)
  );

  // Operands are held for the whole transaction; requests outside IDLE are
  // ignored because w_accept is gated by the idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnw   <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_rnw   <= bus.req_rnw;
      r_row   <= bus.req_addr[ADDR_W-1:COL_BITS];
      r_col   <= bus.req_addr[COL_BITS-1:0];
      r_wdata <= bus.req_wdata;
      r_wmask <= bus.req_wmask;
    end
  end

  assign w_sense_word = sense_data[r_col*WORD_SIZE +: WORD_SIZE];
  assign w_capture    = (w_state == ST_READ) && w_last;

  // Read data only moves on the last sense cycle of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else if (w_capture) r_rdata <= w_sense_word;
  end

  // Row decode and column steering.
  assign w_row_onehot = ROWS'(1) << r_row;
  assign w_mask_steer = COLS'(r_wmask) << (r_col * WORD_SIZE);
  assign w_data_steer = COLS'(r_wdata) << (r_col * WORD_SIZE);

  assign w_wl_on = (w_state == ST_ACT) || (w_state == ST_READ) ||
                   (w_state == ST_WRITE);

  // Each control is decoded from a distinct state, which keeps precharge,
  // wordline/sense and write-drive phases mutually exclusive by construction.
  always_comb begin
    pre_en    = 1'b0;
    wl        = '0;
    sae       = 1'b0;
    bl_drv_en = '0;
    bl_data   = '0;
    if (w_state == ST_PRE) pre_en = 1'b1;
    if (w_wl_on) wl = w_row_onehot;
    if (w_state == ST_READ) sae = 1'b1;
    if (w_state == ST_WRITE) begin
      bl_drv_en = w_mask_steer;
      bl_data   = w_data_steer;
    end
  end

  assign bus.req_ready   = w_idle;
  assign bus.rsp_valid   = (w_state == ST_DONE);
  assign bus.rsp_is_read = (w_state == ST_DONE) && r_rnw;
  assign bus.rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_sram_bank.sv
module tb_sram_bank;

  localparam int unsigned ROWS = 64;
  localparam int unsigned COLS = 64;
  localparam int unsigned AW   = 10;
  localparam int unsigned WS   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus
  logic          sel;      // 0 = default-timing bank, 1 = PRE=3/ACC=2 bank
  logic          v_valid, v_rnw;
  logic [AW-1:0] v_addr;
  logic [WS-1:0] v_wdata, v_wmask;
  logic          arr_clr;

  sram_bank_if #(.ADDR_W(AW), .WORD_SIZE(WS)) bus1 ();
  sram_bank_if #(.ADDR_W(AW), .WORD_SIZE(WS)) bus2 ();

  assign bus1.req_valid = v_valid & ~sel;
  assign bus2.req_valid = v_valid & sel;
  assign bus1.req_rnw   = v_rnw;   assign bus2.req_rnw   = v_rnw;
  assign bus1.req_addr  = v_addr;  assign bus2.req_addr  = v_addr;
  assign bus1.req_wdata = v_wdata; assign bus2.req_wdata = v_wdata;
  assign bus1.req_wmask = v_wmask; assign bus2.req_wmask = v_wmask;

  logic            pre1, sae1, pre2, sae2;
  logic [ROWS-1:0] wl1, wl2;
  logic [COLS-1:0] drv1, bld1, sense1, drv2, bld2, sense2;

  sram_bank #(.ROW_BITS(6), .COL_BITS(4), .WORD_SIZE(4),
              .PRE_CYCLES(1), .ACC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .pre_en(pre1), .wl(wl1), .sae(sae1),
    .bl_drv_en(drv1), .bl_data(bld1), .sense_data(sense1));

  sram_bank #(.ROW_BITS(6), .COL_BITS(4), .WORD_SIZE(4),
              .PRE_CYCLES(3), .ACC_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .pre_en(pre2), .wl(wl2), .sae(sae2),
    .bl_drv_en(drv2), .bl_data(bld2), .sense_data(sense2));

  // Behavioural analog arrays: a driven column under an open wordline takes
  // the bitline value; sense amps show the open row.
  logic [COLS-1:0] arr1 [ROWS];
  logic [COLS-1:0] arr2 [ROWS];

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (arr_clr) begin
        arr1[r] <= '0;
        arr2[r] <= '0;
      end else begin
        if (wl1[r]) arr1[r] <= (arr1[r] & ~drv1) | (bld1 & drv1);
        if (wl2[r]) arr2[r] <= (arr2[r] & ~drv2) | (bld2 & drv2);
      end
    end
  end

  always_comb begin
    sense1 = 64'h5A5A_5A5A_5A5A_5A5A;
    sense2 = 64'h5A5A_5A5A_5A5A_5A5A;
    for (int r = 0; r < ROWS; r++) begin
      if (wl1[r]) sense1 = arr1[r];
      if (wl2[r]) sense2 = arr2[r];
    end
  end

  // observation mux
  logic            m_ready, m_rv, m_isrd, m_pre, m_sae;
  logic [WS-1:0]   m_rdata;
  logic [63:0]     m_wl, m_drv, m_bld;
  always_comb begin
    if (sel) begin
      m_ready = bus2.req_ready; m_rv = bus2.rsp_valid; m_isrd = bus2.rsp_is_read;
      m_rdata = bus2.rsp_rdata; m_pre = pre2; m_sae = sae2;
      m_wl = wl2; m_drv = drv2; m_bld = bld2;
    end else begin
      m_ready = bus1.req_ready; m_rv = bus1.rsp_valid; m_isrd = bus1.rsp_is_read;
      m_rdata = bus1.rsp_rdata; m_pre = pre1; m_sae = sae1;
      m_wl = wl1; m_drv = drv1; m_bld = bld1;
    end
  end

  // word-level reference model
  logic [WS-1:0] wm [1024];
  logic [WS-1:0] last_rd;

  task automatic model_apply(input logic rnw, input logic [AW-1:0] a,
                             input logic [WS-1:0] wd, input logic [WS-1:0] wmk);
    if (rnw) last_rd = wm[a];
    else     wm[a]   = (wm[a] & ~wmk) | (wd & wmk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction. lat counts cycles from the acceptance cycle (inclusive)
  // to the rsp_valid cycle.
  task automatic do_op(input logic rnw, input logic [AW-1:0] a,
                       input logic [WS-1:0] wd, input logic [WS-1:0] wmk,
                       output int lat, output int pre_c, output int sae_c,
                       output int rdy_hi, output logic [63:0] wl_or,
                       output logic [63:0] drv_or, output logic [63:0] bld_or,
                       output logic [WS-1:0] rdata, output logic isrd,
                       output int bad, output logic rdy_back);
    int k;
    @(negedge clk);
    v_rnw = rnw; v_addr = a; v_wdata = wd; v_wmask = wmk; v_valid = 1'b1;
    @(posedge clk); #1;
    v_valid = 1'b0;
    k = 0; pre_c = 0; sae_c = 0; rdy_hi = 0; bad = 0;
    wl_or = '0; drv_or = '0; bld_or = '0;
    while (!m_rv && k < 200) begin
      pre_c += int'(m_pre); sae_c += int'(m_sae); rdy_hi += int'(m_ready);
      wl_or |= m_wl; drv_or |= m_drv; bld_or |= m_bld;
      if ((m_wl & (m_wl - 64'd1)) != 0) bad++;
      if (m_pre && (m_wl != 0)) bad++;
      if (m_sae && (m_drv != 0)) bad++;
      @(posedge clk); #1;
      k++;
    end
    if (!m_rv) begin
      checks++; errors++;
      $display("FAIL op_timeout: got no rsp_valid required rsp_valid within 200 cycles");
    end
    lat = k + 1; rdata = m_rdata; isrd = m_isrd;
    @(posedge clk); #1;
    rdy_back = m_ready;
  endtask

  typedef struct {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [WS-1:0] wd, wmk, exp_rd;
    int            exp_row;
    logic [63:0]   exp_drv, exp_bld;
  } vec_t;
  vec_t vt [10];

  int lat, pre_c, sae_c, rdy_hi, bad, k;
  logic [63:0] wl_or, drv_or, bld_or;
  logic [WS-1:0] rdata;
  logic isrd, rdy_back, seen_rv;
  logic rnw_r;
  logic [AW-1:0] a_r;
  logic [WS-1:0] wd_r, wmk_r;

  initial begin
    vt[0] = '{1'b0, 10'h3A5, 4'hA, 4'hF, 4'h0, 58, 64'h0000_0000_00F0_0000, 64'h0000_0000_00A0_0000};
    vt[1] = '{1'b1, 10'h3A5, 4'h0, 4'h0, 4'hA, 58, 64'h0, 64'h0};
    vt[2] = '{1'b0, 10'h3A5, 4'h5, 4'h3, 4'hA, 58, 64'h0000_0000_0030_0000, 64'h0000_0000_0050_0000};
    vt[3] = '{1'b1, 10'h3A5, 4'h0, 4'h0, 4'h9, 58, 64'h0, 64'h0};
    vt[4] = '{1'b0, 10'h000, 4'hF, 4'hF, 4'h9, 0,  64'h0000_0000_0000_000F, 64'h0000_0000_0000_000F};
    vt[5] = '{1'b1, 10'h000, 4'h0, 4'h0, 4'hF, 0,  64'h0, 64'h0};
    vt[6] = '{1'b0, 10'h3FF, 4'h6, 4'hF, 4'hF, 63, 64'hF000_0000_0000_0000, 64'h6000_0000_0000_0000};
    vt[7] = '{1'b1, 10'h3FF, 4'h0, 4'h0, 4'h6, 63, 64'h0, 64'h0};
    vt[8] = '{1'b0, 10'h3FF, 4'h9, 4'h0, 4'h6, 63, 64'h0, 64'h9000_0000_0000_0000};
    vt[9] = '{1'b1, 10'h3FF, 4'h0, 4'h0, 4'h6, 63, 64'h0, 64'h0};

    for (int i = 0; i < 1024; i++) wm[i] = '0;
    last_rd = '0;

    // reset with a request held present
    sel = 1'b0; arr_clr = 1'b1; rst_n = 1'b0;
    v_valid = 1'b1; v_rnw = 1'b0; v_addr = 10'h155; v_wdata = 4'hF; v_wmask = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",   64'(m_ready), 64'd1);
    check("rst_rsp_valid",   64'(m_rv),    64'd0);
    check("rst_rsp_is_read", 64'(m_isrd),  64'd0);
    check("rst_rsp_rdata",   64'(m_rdata), 64'd0);
    check("rst_pre_en",      64'(m_pre),   64'd0);
    check("rst_wl",          m_wl,         64'd0);
    check("rst_sae",         64'(m_sae),   64'd0);
    check("rst_bl_drv_en",   m_drv,        64'd0);
    check("rst_bl_data",     m_bld,        64'd0);
    check("rst_bank2_wl",    wl2,          64'd0);
    rst_n = 1'b1; arr_clr = 1'b0;
    @(posedge clk); #1;
    v_valid = 1'b0;
    check("first_edge_pre_en",    64'(m_pre),   64'd1);
    check("first_edge_req_ready", 64'(m_ready), 64'd0);
    seen_rv = 1'b0;
    for (int i = 0; i < 20 && !seen_rv; i++) begin
      @(posedge clk); #1;
      seen_rv = m_rv;
    end
    check("first_op_rsp_valid", 64'(seen_rv), 64'd1);
    @(posedge clk); #1;

    // directed vector table on the default-timing bank
    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].rnw, vt[i].addr, vt[i].wd, vt[i].wmk,
            lat, pre_c, sae_c, rdy_hi, wl_or, drv_or, bld_or, rdata, isrd, bad, rdy_back);
      model_apply(vt[i].rnw, vt[i].addr, vt[i].wd, vt[i].wmk);
      check($sformatf("vec%0d_wl", i),        wl_or,         64'd1 << vt[i].exp_row);
      check($sformatf("vec%0d_drv", i),       drv_or,        vt[i].exp_drv);
      check($sformatf("vec%0d_bl_data", i),   bld_or,        vt[i].exp_bld);
      check($sformatf("vec%0d_rdata", i),     64'(rdata),    64'(vt[i].exp_rd));
      check($sformatf("vec%0d_is_read", i),   64'(isrd),     64'(vt[i].rnw));
      check($sformatf("vec%0d_latency", i),   64'(lat),      64'd4);
      check($sformatf("vec%0d_pre_cycles", i), 64'(pre_c),   64'd1);
      check($sformatf("vec%0d_ready_low", i), 64'(rdy_hi),   64'd0);
      check($sformatf("vec%0d_exclusive", i), 64'(bad),      64'd0);
      check($sformatf("vec%0d_ready_back", i), 64'(rdy_back), 64'd1);
    end

    // longer phases on the second bank
    sel = 1'b1;
    do_op(1'b0, 10'h2C7, 4'hC, 4'hF, lat, pre_c, sae_c, rdy_hi, wl_or, drv_or, bld_or,
          rdata, isrd, bad, rdy_back);
    check("long_wr_pre_cycles", 64'(pre_c),  64'd3);
    check("long_wr_latency",    64'(lat),    64'd7);
    check("long_wr_ready_low",  64'(rdy_hi), 64'd0);
    check("long_wr_drv",        drv_or,      64'h0000_0000_F000_0000);
    do_op(1'b1, 10'h2C7, 4'h0, 4'h0, lat, pre_c, sae_c, rdy_hi, wl_or, drv_or, bld_or,
          rdata, isrd, bad, rdy_back);
    check("long_rd_pre_cycles", 64'(pre_c),  64'd3);
    check("long_rd_sae_cycles", 64'(sae_c),  64'd2);
    check("long_rd_latency",    64'(lat),    64'd7);
    check("long_rd_ready_low",  64'(rdy_hi), 64'd0);
    check("long_rd_rdata",      64'(rdata),  64'hC);
    check("long_rd_wl",         wl_or,       64'd1 << 44);
    check("long_rd_exclusive",  64'(bad),    64'd0);
    sel = 1'b0;

    // reset asserted during READ
    @(negedge clk);
    v_rnw = 1'b1; v_addr = 10'h000; v_valid = 1'b1;
    @(posedge clk); #1;
    v_valid = 1'b0;
    k = 0;
    while (!m_sae && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("midrd_reached_read", 64'(m_sae), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrd_wl_drop",  m_wl,         64'd0);
    check("midrd_sae_drop", 64'(m_sae),   64'd0);
    check("midrd_rdata",    64'(m_rdata), 64'd0);
    check("midrd_no_rsp",   64'(m_rv),    64'd0);
    seen_rv = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen_rv |= m_rv;
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_rv |= m_rv;
    end
    check("midrd_no_rsp_after", 64'(seen_rv), 64'd0);
    do_op(1'b1, 10'h000, 4'h0, 4'h0, lat, pre_c, sae_c, rdy_hi, wl_or, drv_or, bld_or,
          rdata, isrd, bad, rdy_back);
    model_apply(1'b1, 10'h000, 4'h0, 4'h0);
    check("post_rst_rdata",   64'(rdata), 64'(wm[0]));
    check("post_rst_latency", 64'(lat),   64'd4);

    // randomized traffic against the word model
    for (int n = 0; n < 60; n++) begin
      rnw_r = 1'($urandom_range(0, 1));
      a_r   = 10'($urandom_range(0, 1023));
      wd_r  = 4'($urandom_range(0, 15));
      wmk_r = 4'($urandom_range(0, 15));
      do_op(rnw_r, a_r, wd_r, wmk_r, lat, pre_c, sae_c, rdy_hi, wl_or, drv_or, bld_or,
            rdata, isrd, bad, rdy_back);
      check($sformatf("rnd%0d_wl", n), wl_or, 64'd1 << a_r[9:4]);
      check($sformatf("rnd%0d_drv", n), drv_or,
            rnw_r ? 64'd0 : (64'(wmk_r) << (32'(a_r[3:0]) * 4)));
      check($sformatf("rnd%0d_rdata", n), 64'(rdata), rnw_r ? 64'(wm[a_r]) : 64'(last_rd));
      check($sformatf("rnd%0d_is_read", n), 64'(isrd), 64'(rnw_r));
      check($sformatf("rnd%0d_latency", n), 64'(lat), 64'd4);
      check($sformatf("rnd%0d_exclusive", n), 64'(bad), 64'd0);
      model_apply(rnw_r, a_r, wd_r, wmk_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
